uart_work_loader: RTL and testbench

UART_WORK_LOADER -- requirements
Module: uart_work_loader

---
 rtl/miner_uart_pkg.sv | 14 +
 rtl/uart_work_loader.sv | 176 +++++++++++++++++
 tb/tb_uart_work_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/miner_uart_pkg.sv
// Shared definitions for the miner UART work-loader slice: the loader state
// encoding and the default packet/counter sizing used by uart_work_loader.
package miner_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned DEF_PACKET_BYTES = 44;
  localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/uart_work_loader.sv
// uart_work_loader: assembles a fixed-length work packet from a byte stream
// delivered by an external UART receiver, holds it until the consumer
// acknowledges it, and counts short packets, overruns and checksum failures
// in saturating counters.
// Optional feature macro: WORK_CHECKSUM_EN (adds a trailing XOR checksum byte).
module uart_work_loader
  import miner_uart_pkg::*;
#(
  parameter int unsigned PACKET_BYTES = DEF_PACKET_BYTES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_data_ready,
  input  logic [7:0]                rx_data,
  input  logic                      rx_endofpacket,
  output logic [8*PACKET_BYTES-1:0] work_data,
  output logic                      work_valid,
  input  logic                      work_ack,
  output logic [CNT_W-1:0]          err_short,
  output logic [CNT_W-1:0]          err_overrun,
  output logic [CNT_W-1:0]          err_csum,
  output logic                      busy
);

`ifdef WORK_CHECKSUM_EN
  localparam int unsigned PKT_LEN = PACKET_BYTES + 1;
`else
  localparam int unsigned PKT_LEN = PACKET_BYTES;
`endif
  localparam int unsigned DW      = 8 * PACKET_BYTES;
  localparam int unsigned CW      = $clog2(PACKET_BYTES + 2);
  localparam logic [CW-1:0] LAST  = CW'(PKT_LEN);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      cnt_n;
  logic [DW-1:0]      work_data_q, work_data_d;
  logic [DW-1:0]      shifted;
  logic               work_valid_q, work_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   err_short_q, err_short_d;
  logic [CNT_W-1:0]   err_overrun_q, err_overrun_d;
`ifdef WORK_CHECKSUM_EN
  logic [CNT_W-1:0]   err_csum_q, err_csum_d;
  logic [7:0]         csum_q, csum_d;
`endif

  // Next-state, datapath and error-counter update for the loader FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cnt_n         = cnt_q;
    work_data_d   = work_data_q;
    err_short_d   = err_short_q;
    err_overrun_d = err_overrun_q;
    shifted       = {work_data_q[DW-9:0], rx_data};
`ifdef WORK_CHECKSUM_EN
    err_csum_d    = err_csum_q;
    csum_d        = csum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (rx_data_ready) begin
          work_data_d = shifted;
          cnt_d       = CW'(1);
          state_d     = RECV;
`ifdef WORK_CHECKSUM_EN
          csum_d      = rx_data;
`endif
        end
      end

      RECV: begin
        // A byte arriving with end-of-packet is counted before the
        // completeness check, so cnt_n carries the updated count.
        if (rx_data_ready) begin
          cnt_n = cnt_q + CW'(1);
          cnt_d = cnt_n;
`ifdef WORK_CHECKSUM_EN
          if (cnt_n != LAST) begin
            work_data_d = shifted;
            csum_d      = csum_q ^ rx_data;
          end
`else
          work_data_d = shifted;
`endif
        end
        if (cnt_n == LAST) begin
          cnt_d = '0;
`ifdef WORK_CHECKSUM_EN
          if (csum_q == rx_data) begin
            state_d = HOLD;
          end else begin
            state_d    = IDLE;
            err_csum_d = (err_csum_q == '1) ? err_csum_q : err_csum_q + CNT_W'(1);
          end
`else
          state_d = HOLD;
`endif
        end else if (rx_endofpacket) begin
          cnt_d       = '0;
          state_d     = IDLE;
          err_short_d = (err_short_q == '1) ? err_short_q : err_short_q + CNT_W'(1);
        end
      end

      HOLD: begin
        if (work_ack) begin
          if (rx_data_ready) begin
            work_data_d = shifted;
            cnt_d       = CW'(1);
            state_d     = RECV;
`ifdef WORK_CHECKSUM_EN
            csum_d      = rx_data;
`endif
          end else begin
            state_d = IDLE;
          end
        end else if (rx_data_ready) begin
          err_overrun_d = (err_overrun_q == '1) ? err_overrun_q : err_overrun_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    work_valid_d = (state_d == HOLD);
    busy_d       = (state_d != IDLE);
  end

  // State and output registers; reset discards any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      work_data_q   <= '0;
      work_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_short_q   <= '0;
      err_overrun_q <= '0;
`ifdef WORK_CHECKSUM_EN
      err_csum_q    <= '0;
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      work_data_q   <= work_data_d;
      work_valid_q  <= work_valid_d;
      busy_q        <= busy_d;
      err_short_q   <= err_short_d;
      err_overrun_q <= err_overrun_d;
`ifdef WORK_CHECKSUM_EN
      err_csum_q    <= err_csum_d;
      csum_q        <= csum_d;
`endif
    end
  end

  assign work_data   = work_data_q;
  assign work_valid  = work_valid_q;
  assign busy        = busy_q;
  assign err_short   = err_short_q;
  assign err_overrun = err_overrun_q;
`ifdef WORK_CHECKSUM_EN
  assign err_csum    = err_csum_q;
`else
  assign err_csum    = '0;
`endif

endmodule

// File: tb/tb_uart_work_loader.sv
// Directed self-checking bench for uart_work_loader with 4-byte packets.
// Builds with or without WORK_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_uart_work_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_data_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_endofpacket = 1'b0;
  logic [31:0] work_data;
  logic        work_valid;
  logic        work_ack = 1'b0;
  logic [7:0]  err_short, err_overrun, err_csum;
  logic        busy;

  int errors = 0;
  int checks = 0;

  uart_work_loader #(.PACKET_BYTES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .rx_data_ready(rx_data_ready), .rx_data(rx_data), .rx_endofpacket(rx_endofpacket),
    .work_data(work_data), .work_valid(work_valid), .work_ack(work_ack),
    .err_short(err_short), .err_overrun(err_overrun), .err_csum(err_csum),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // All drive tasks start and end 1ns after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data_ready = 1'b1;
    rx_data       = b;
    @(posedge clk); #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic send_eop();
    rx_endofpacket = 1'b1;
    @(posedge clk); #1;
    rx_endofpacket = 1'b0;
  endtask

  task automatic send_ack();
    work_ack = 1'b1;
    @(posedge clk); #1;
    work_ack = 1'b0;
  endtask

  // Sends the three trailing bytes of a packet (plus checksum when enabled).
  task automatic send_tail(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b1);
    send_byte(b2);
`ifdef WORK_CHECKSUM_EN
    send_byte(b3);
    send_byte(b0 ^ b1 ^ b2 ^ b3);
`else
    send_byte(b3);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (work_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", work_valid); end
    checks++; if (work_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=00000000", work_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({err_short, err_overrun, err_csum} !== 24'h0) begin errors++; $display("FAIL reset_errs got=%h exp=000000", {err_short, err_overrun, err_csum}); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send_byte(8'h11);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    send_byte(8'h22);
    send_byte(8'h33);
`ifdef WORK_CHECKSUM_EN
    send_byte(8'h44);
    checks++; if (work_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", work_valid); end
    send_byte(8'h44);  // 11^22^33^44 = 44
`else
    checks++; if (work_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", work_valid); end
    send_byte(8'h44);
`endif
    checks++; if (work_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", work_valid); end
    checks++; if (work_data !== 32'h11223344) begin errors++; $display("FAIL basic_data got=%h exp=11223344", work_data); end
    send_ack();
    checks++; if (work_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_valid got=%b exp=0", work_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_ack_busy got=%b exp=0", busy); end
  endtask

  task automatic test_short();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_eop();
    checks++; if (err_short !== 8'd1) begin errors++; $display("FAIL short_cnt got=%0d exp=1", err_short); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got=%b exp=0", busy); end
    checks++; if (work_valid !== 1'b0) begin errors++; $display("FAIL short_valid got=%b exp=0", work_valid); end
    send_eop();  // idle end-of-packet is ignored
    checks++; if (err_short !== 8'd1) begin errors++; $display("FAIL short_idle_eop got=%0d exp=1", err_short); end
  endtask

  task automatic test_overrun();
    send_byte(8'hA1);
    send_tail(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    checks++; if (work_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", work_valid); end
    send_byte(8'h55);
    checks++; if (err_overrun !== 8'd1) begin errors++; $display("FAIL ovr_cnt got=%0d exp=1", err_overrun); end
    checks++; if (work_data !== 32'hA1B2C3D4) begin errors++; $display("FAIL ovr_data got=%h exp=a1b2c3d4", work_data); end
    send_eop();  // end-of-packet while holding is ignored
    checks++; if (err_short !== 8'd1 || work_valid !== 1'b1) begin errors++; $display("FAIL hold_eop got=%0d/%b exp=1/1", err_short, work_valid); end
    work_ack = 1'b1;
    send_byte(8'h66);
    work_ack = 1'b0;
    checks++; if (work_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ackbyte_state got=%b/%b exp=0/1", work_valid, busy); end
    send_tail(8'h66, 8'h77, 8'h88, 8'h99);
    checks++; if (work_valid !== 1'b1) begin errors++; $display("FAIL ackbyte_valid got=%b exp=1", work_valid); end
    checks++; if (work_data !== 32'h66778899) begin errors++; $display("FAIL ackbyte_data got=%h exp=66778899", work_data); end
    checks++; if (err_overrun !== 8'd1) begin errors++; $display("FAIL ackbyte_ovr got=%0d exp=1", err_overrun); end
    send_ack();
  endtask

  task automatic test_checksum();
`ifdef WORK_CHECKSUM_EN
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0F);
    checks++; if (work_valid !== 1'b1) begin errors++; $display("FAIL csum_ok_valid got=%b exp=1", work_valid); end
    checks++; if (work_data !== 32'h01020408) begin errors++; $display("FAIL csum_ok_data got=%h exp=01020408", work_data); end
    send_ack();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0E);
    checks++; if (err_csum !== 8'd1) begin errors++; $display("FAIL csum_bad_cnt got=%0d exp=1", err_csum); end
    checks++; if (work_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL csum_bad_state got=%b/%b exp=0/0", work_valid, busy); end
`else
    checks++; if (err_csum !== 8'd0) begin errors++; $display("FAIL csum_tied got=%0d exp=0", err_csum); end
`endif
  endtask

  task automatic test_reset_mid();
    send_byte(8'hCC);
    send_byte(8'hDD);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h12);
    send_tail(8'h12, 8'h34, 8'h56, 8'h78);
    checks++; if (work_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got=%b exp=1", work_valid); end
    checks++; if (work_data !== 32'h12345678) begin errors++; $display("FAIL rstmid_data got=%h exp=12345678", work_data); end
    checks++; if ({err_short, err_overrun, err_csum} !== 24'h0) begin errors++; $display("FAIL rstmid_errs got=%h exp=000000", {err_short, err_overrun, err_csum}); end
  endtask

  // Packet 0x12345678 from the previous task is still held unacknowledged.
  task automatic test_saturation();
    for (int i = 0; i < 254; i++) send_byte(i[7:0]);
    checks++; if (err_overrun !== 8'hFE) begin errors++; $display("FAIL sat_254 got=%h exp=fe", err_overrun); end
    for (int i = 0; i < 5; i++) send_byte(8'h5A);
    checks++; if (err_overrun !== 8'hFF) begin errors++; $display("FAIL sat_259 got=%h exp=ff", err_overrun); end
    checks++; if (work_data !== 32'h12345678 || work_valid !== 1'b1) begin errors++; $display("FAIL sat_hold got=%h/%b exp=12345678/1", work_data, work_valid); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_short();
    test_overrun();
    test_checksum();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
